// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
//   state_t   : frame FSM states (ACCUM -> RESOLVE -> OUTPUT -> ACCUM)
//   n_chunks  : number of CPA_W-wide resolve chunks in an ACC_W accumulator
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    function automatic int unsigned n_chunks(input int unsigned acc_w,
                                             input int unsigned cpa_w);
        return acc_w / cpa_w;
    endfunction

endpackage

// File: rtl/csa_compress_3to2.sv
// Bitwise 3:2 compressor (a row of full adders without carry chaining).
// Ports:
//   a, b, c : W-bit operands
//   s       : W-bit sum bits, a ^ b ^ c
//   maj     : W-bit majority bits; the caller shifts these left by one
module csa_compress_3to2 #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] maj
);

    assign s   = a ^ b ^ c;
    assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator. Operands of a frame are folded into a
// redundant sum/carry pair with one 3:2 compression per accepted operand. The
// operand flagged in_last starts a chunked carry-propagate resolve (one CPA_W
// chunk per cycle); the resolved sum is then offered on a valid/ready port.
// All arithmetic is modulo 2^ACC_W; overflow wraps silently.
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : operand valid          in_ready  : operand accepted (ACCUM only)
//   in_data    : DATA_W-bit operand      in_last   : final operand of the frame
//   out_valid  : resolved sum valid      out_ready : consumer accepts the sum
//   out_data   : ACC_W-bit frame sum, held stable while out_valid is high
//   out_count  : operands in the frame, saturating (only with CSA_CNT_EN)
//
// Build option: define CSA_CNT_EN to add the operand counter and out_count.
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned CPA_W  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
`ifdef CSA_CNT_EN
    ,
    output logic [CNT_W-1:0]  out_count
`endif
);

    localparam int unsigned N_CHUNKS = n_chunks(ACC_W, CPA_W);
    localparam int unsigned IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    if (ACC_W % CPA_W != 0) begin : g_bad_chunk
        $error("csa_stream_accumulator: ACC_W must be a multiple of CPA_W");
    end
    if (DATA_W > ACC_W) begin : g_bad_width
        $error("csa_stream_accumulator: DATA_W must not exceed ACC_W");
    end

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  s_q, s_d;
    logic [ACC_W-1:0]  c_q, c_d;
    logic [ACC_W-1:0]  res_q, res_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cin_q, cin_d;

    logic [ACC_W-1:0]  x_ext;
    logic [ACC_W-1:0]  csa_s;
    logic [ACC_W-1:0]  csa_maj;
    logic [CPA_W-1:0]  s_chunk;
    logic [CPA_W-1:0]  c_chunk;
    logic [CPA_W:0]    chunk_sum;
    logic              accept;
    logic              deliver;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign out_data  = res_q;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign x_ext     = ACC_W'(in_data);

    csa_compress_3to2 #(
        .W (ACC_W)
    ) u_compress (
        .a   (s_q),
        .b   (c_q),
        .c   (x_ext),
        .s   (csa_s),
        .maj (csa_maj)
    );

    // One chunk of the final carry-propagate add per RESOLVE cycle.
    assign s_chunk   = s_q[idx_q*CPA_W +: CPA_W];
    assign c_chunk   = c_q[idx_q*CPA_W +: CPA_W];
    assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + (CPA_W + 1)'(cin_q);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        res_d   = res_q;
        idx_d   = idx_q;
        cin_d   = cin_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    s_d = csa_s;
                    // Carry weight is one bit up; the MSB carry falls off (mod 2^ACC_W).
                    c_d = csa_maj << 1;
                    if (in_last) begin
                        state_d = RESOLVE;
                        idx_d   = '0;
                        cin_d   = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                res_d[idx_q*CPA_W +: CPA_W] = chunk_sum[CPA_W-1:0];
                cin_d = chunk_sum[CPA_W];
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (deliver) begin
                    s_d     = '0;
                    c_d     = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
        end
    end

`ifdef CSA_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counting stops in RESOLVE/OUTPUT because accept is gated by in_ready.
    always_comb begin
        cnt_d = cnt_q;
        if (deliver) begin
            cnt_d = '0;
        end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed self-checking bench for csa_stream_accumulator (default parameters).
// Covers out_count checks when built with CSA_CNT_EN.
module tb_csa_stream_accumulator;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef CSA_CNT_EN
    logic [7:0]  out_count;
`endif

    int total = 0;
    int bad   = 0;

    csa_stream_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef CSA_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one operand at the falling edge; it is taken on the next rising edge.
    task automatic push(input logic [7:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check("push_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic collect(input string tag, input logic [15:0] exp_data,
                           input logic [7:0] exp_cnt);
        wait_valid(tag);
        check(tag, 32'(out_data), 32'(exp_data));
`ifdef CSA_CNT_EN
        check(tag, 32'(out_count), 32'(exp_cnt));
`else
        if (exp_cnt == 8'd0) $display("note: zero count requested for %s", tag);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("after_handshake_valid", 32'(out_valid), 32'd0);
        check("after_handshake_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
`ifdef CSA_CNT_EN
        check("reset_out_count", 32'(out_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Basic frame with exact latency: valid only after the N-th edge.
        push(8'd10, 1'b0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b1);
        check("basic_resolve_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k < N; k++) begin
            @(posedge clk);
            #1;
            check("basic_latency_early", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check("basic_latency_n", 32'(out_valid), 32'd1);
        collect("basic_60", 16'd60, 8'd3);

        // Single operand frame.
        push(8'd255, 1'b1);
        collect("single_255", 16'd255, 8'd1);

        // 300 x 255 = 76500 wraps to 10964; count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            push(8'd255, (i == 299));
        end
        collect("wrap_10964", 16'd10964, 8'd255);

        // Backpressure: result and a pending operand must both be held.
        push(8'd40, 1'b0);
        push(8'd2, 1'b1);
        wait_valid("bp_valid");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd5;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'd42);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
`ifdef CSA_CNT_EN
        check("bp_out_count", 32'(out_count), 32'd2);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        collect("bp_held_operand_5", 16'd5, 8'd1);

        // Back-to-back frames, no residue between them.
        push(8'd1, 1'b0);
        push(8'd2, 1'b1);
        collect("b2b_3", 16'd3, 8'd2);
        push(8'd100, 1'b1);
        collect("b2b_100", 16'd100, 8'd1);

        // Reset while chunk 2 is being resolved.
        push(8'd9, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(8'd7, 1'b1);
        collect("after_reset_7", 16'd7, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
